// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus encodings and MDU sequencer state codes for the pipeline
// hazard controller.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}; the lowest NO_STOP above a STOP takes a bubble.
    localparam stall_bus_t STALL_NONE = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP};
    localparam stall_bus_t STALL_LOAD = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    localparam stall_bus_t STALL_MDU  = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};

    localparam logic [0:0] MDU_IDLE = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;

endpackage

// File: rtl/pipe_stall_ctrl_sat_cnt32.sv
// 32-bit saturating event counter with enable and synchronous clear.
module sat_cnt32 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Merges flush, MDU busy and load-use hazards into one prioritized stall bus,
// with a first-stall strobe and saturating stall-cycle counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned MDU_MAX_CYC    = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_load,
    input  logic               mdu_start,
    input  logic               mdu_done,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               stall_first,
    output logic               mdu_busy,
    output logic               mdu_abort,
    output logic               mdu_timeout,
    output logic [31:0]        load_stall_cnt,
    output logic [31:0]        mdu_stall_cnt
);

    localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL_CYC - 1);
    localparam logic [7:0] CYC_MAX   = 8'(MDU_MAX_CYC);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] cyc_cnt;
    logic [2:0] hold;
    logic       prev_stall1;
    logic       mdu_stalling;
    logic       load_stalling;
    logic       tmo_hit;
    stall_bus_t stall_int;

    always_comb begin
        mdu_stalling = 1'b0;
        tmo_hit      = 1'b0;
        state_nxt    = state;
        if (flush_req) begin
            state_nxt = MDU_IDLE;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (mdu_start && !mdu_done) begin
                        mdu_stalling = 1'b1;
                        state_nxt    = MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_done) begin
                        state_nxt = MDU_IDLE;
                    end else if (cyc_cnt == CYC_MAX) begin
                        tmo_hit   = 1'b1;
                        state_nxt = MDU_IDLE;
                    end else begin
                        mdu_stalling = 1'b1;
                    end
                end
                default: state_nxt = MDU_IDLE;
            endcase
        end
    end

    assign load_stalling = !flush_req && !mdu_stalling && (stallreq_load || (hold != '0));

    always_comb begin
        stall_int = STALL_NONE;
        if (flush_req) begin
            stall_int = STALL_NONE;
        end else if (mdu_stalling) begin
            stall_int = STALL_MDU;
        end else if (load_stalling) begin
            stall_int = STALL_LOAD;
        end
    end

    // Combinational outputs are held quiet while reset is asserted.
    assign stall       = rst ? STALL_NONE : stall_int;
    assign flush       = flush_req && !rst;
    assign mdu_busy    = (state == MDU_BUSY);
    assign mdu_abort   = !rst && ((flush_req && (mdu_busy || mdu_start)) || tmo_hit);
    assign stall_first = stall[1] && !prev_stall1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MDU_IDLE;
            cyc_cnt     <= '0;
            hold        <= '0;
            prev_stall1 <= 1'b0;
            mdu_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_stall1 <= flush_req ? 1'b0 : stall[1];
            if (tmo_hit) begin
                mdu_timeout <= 1'b1;
            end
            if ((state == MDU_IDLE) && (state_nxt == MDU_BUSY)) begin
                cyc_cnt <= 8'd1;
            end else if ((state == MDU_BUSY) && mdu_stalling) begin
                cyc_cnt <= cyc_cnt + 8'd1;
            end
            // An MDU stall freezes any pending load hold so it resumes afterwards.
            if (flush_req) begin
                hold <= '0;
            end else if (!mdu_stalling) begin
                if (hold != '0) begin
                    hold <= hold - 3'd1;
                end else if (stallreq_load) begin
                    hold <= HOLD_INIT;
                end
            end
        end
    end

    sat_cnt32 u_load_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall == STALL_LOAD),
        .cnt (load_stall_cnt)
    );

    sat_cnt32 u_mdu_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall == STALL_MDU),
        .cnt (mdu_stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: two instances (default and short
// hold/timeout parameters) driven by directed vectors with hand-derived results.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SL = 6'b000111;
    localparam logic [5:0] SM = 6'b001111;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        first;
        logic        busy;
        logic        abort;
        logic        tmo;
        logic [31:0] lcnt;
        logic [31:0] mcnt;
    } obs_t;

    typedef struct {
        int    sel;
        string name;
        obs_t  exp;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [2];
    logic        ld_v   [2];
    logic        st_v   [2];
    logic        dn_v   [2];
    logic        fl_v   [2];
    logic [5:0]  stall_v[2];
    logic        flush_v[2];
    logic        first_v[2];
    logic        busy_v [2];
    logic        abort_v[2];
    logic        tmo_v  [2];
    logic [31:0] lcnt_v [2];
    logic [31:0] mcnt_v [2];

    sb_t sbq[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    pipe_stall_ctrl u_dut_a (
        .clk            (clk),
        .rst            (rst_v[0]),
        .stallreq_load  (ld_v[0]),
        .mdu_start      (st_v[0]),
        .mdu_done       (dn_v[0]),
        .flush_req      (fl_v[0]),
        .stall          (stall_v[0]),
        .flush          (flush_v[0]),
        .stall_first    (first_v[0]),
        .mdu_busy       (busy_v[0]),
        .mdu_abort      (abort_v[0]),
        .mdu_timeout    (tmo_v[0]),
        .load_stall_cnt (lcnt_v[0]),
        .mdu_stall_cnt  (mcnt_v[0])
    );

    pipe_stall_ctrl #(
        .LOAD_STALL_CYC (3),
        .MDU_MAX_CYC    (4)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst_v[1]),
        .stallreq_load  (ld_v[1]),
        .mdu_start      (st_v[1]),
        .mdu_done       (dn_v[1]),
        .flush_req      (fl_v[1]),
        .stall          (stall_v[1]),
        .flush          (flush_v[1]),
        .stall_first    (first_v[1]),
        .mdu_busy       (busy_v[1]),
        .mdu_abort      (abort_v[1]),
        .mdu_timeout    (tmo_v[1]),
        .load_stall_cnt (lcnt_v[1]),
        .mdu_stall_cnt  (mcnt_v[1])
    );

    function automatic obs_t mk(input logic [5:0] s, input logic f, input logic fi,
                                input logic b, input logic a, input logic t,
                                input logic [31:0] l, input logic [31:0] m);
        obs_t o;
        o.stall = s; o.flush = f; o.first = fi; o.busy = b;
        o.abort = a; o.tmo = t; o.lcnt = l; o.mcnt = m;
        return o;
    endfunction

    // Drive one cycle of inputs on instance d; the other instance sees idle hazard inputs.
    task automatic step(input int d, input logic r, input logic ld, input logic st,
                        input logic dn, input logic fl, input bit chk,
                        input string nm, input obs_t e);
        sb_t s;
        @(posedge clk);
        #1;
        ld_v[1-d] = 1'b0; st_v[1-d] = 1'b0; dn_v[1-d] = 1'b0; fl_v[1-d] = 1'b0;
        rst_v[d] = r; ld_v[d] = ld; st_v[d] = st; dn_v[d] = dn; fl_v[d] = fl;
        if (chk) begin
            s.sel = d; s.name = nm; s.exp = e;
            sbq.push_back(s);
        end
    endtask

    initial begin : monitor
        sb_t  s;
        obs_t got;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                s = sbq.pop_front();
                got = mk(stall_v[s.sel], flush_v[s.sel], first_v[s.sel], busy_v[s.sel],
                         abort_v[s.sel], tmo_v[s.sel], lcnt_v[s.sel], mcnt_v[s.sel]);
                n_checks++;
                if (got === s.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s dut%0d: got stall=%b flush=%b first=%b busy=%b abort=%b tmo=%b lcnt=%0d mcnt=%0d; expected stall=%b flush=%b first=%b busy=%b abort=%b tmo=%b lcnt=%0d mcnt=%0d",
                             s.name, s.sel, got.stall, got.flush, got.first, got.busy, got.abort,
                             got.tmo, got.lcnt, got.mcnt, s.exp.stall, s.exp.flush, s.exp.first,
                             s.exp.busy, s.exp.abort, s.exp.tmo, s.exp.lcnt, s.exp.mcnt);
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; ld_v[i] = 1'b0; st_v[i] = 1'b0; dn_v[i] = 1'b0; fl_v[i] = 1'b0;
        end
        @(posedge clk);
        step(0, 1, 0, 0, 0, 0, 1, "reset_a", mk(S0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0, 0, 1, "reset_b", mk(S0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 0, "", mk(S0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 0, "", mk(S0, 0, 0, 0, 0, 0, 0, 0));

        // Instance A: LOAD_STALL_CYC=1, MDU_MAX_CYC=40
        step(0, 0, 1, 0, 0, 0, 1, "load1",        mk(SL, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 1, "load1_rel",    mk(S0, 0, 0, 0, 0, 0, 1, 0));
        step(0, 0, 1, 0, 0, 0, 1, "load2_first",  mk(SL, 0, 1, 0, 0, 0, 1, 0));
        step(0, 0, 1, 0, 0, 0, 1, "load2_second", mk(SL, 0, 0, 0, 0, 0, 2, 0));
        step(0, 0, 0, 0, 0, 0, 1, "load2_rel",    mk(S0, 0, 0, 0, 0, 0, 3, 0));

        step(0, 0, 0, 1, 0, 0, 1, "mdu_start",    mk(SM, 0, 1, 0, 0, 0, 3, 0));
        for (int k = 1; k <= 32; k++) begin
            step(0, 0, (k == 5), (k == 10), 0, 0, 1, "mdu_busy",
                 mk(SM, 0, 0, 1, 0, 0, 3, 32'(k)));
        end
        step(0, 0, 0, 0, 1, 0, 1, "mdu_done",     mk(S0, 0, 0, 1, 0, 0, 3, 33));
        step(0, 0, 0, 0, 0, 0, 1, "mdu_idle",     mk(S0, 0, 0, 0, 0, 0, 3, 33));

        step(0, 0, 0, 1, 1, 0, 1, "mdu_single",   mk(S0, 0, 0, 0, 0, 0, 3, 33));
        step(0, 0, 0, 0, 0, 0, 1, "mdu_single_after", mk(S0, 0, 0, 0, 0, 0, 3, 33));

        step(0, 0, 0, 1, 0, 0, 1, "fl_mdu_start", mk(SM, 0, 1, 0, 0, 0, 3, 33));
        step(0, 0, 0, 0, 0, 0, 1, "fl_mdu_busy",  mk(SM, 0, 0, 1, 0, 0, 3, 34));
        step(0, 0, 0, 0, 0, 1, 1, "fl_mdu_flush", mk(S0, 1, 0, 1, 1, 0, 3, 35));
        step(0, 0, 0, 0, 0, 0, 1, "fl_mdu_idle",  mk(S0, 0, 0, 0, 0, 0, 3, 35));

        step(0, 0, 1, 0, 0, 1, 1, "fl_over_load", mk(S0, 1, 0, 0, 0, 0, 3, 35));
        step(0, 0, 1, 0, 0, 0, 1, "load_after_fl", mk(SL, 0, 1, 0, 0, 0, 3, 35));
        step(0, 0, 0, 0, 0, 0, 1, "load_after_rel", mk(S0, 0, 0, 0, 0, 0, 4, 35));

        step(0, 0, 0, 1, 0, 1, 1, "fl_start_idle", mk(S0, 1, 0, 0, 1, 0, 4, 35));
        step(0, 0, 0, 0, 0, 0, 1, "fl_start_after", mk(S0, 0, 0, 0, 0, 0, 4, 35));

        // Instance B: LOAD_STALL_CYC=3, MDU_MAX_CYC=4
        step(1, 0, 1, 0, 0, 0, 1, "hold3_c0",     mk(SL, 0, 1, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 1, "hold3_c1",     mk(SL, 0, 0, 0, 0, 0, 1, 0));
        step(1, 0, 0, 0, 0, 0, 1, "hold3_c2",     mk(SL, 0, 0, 0, 0, 0, 2, 0));
        step(1, 0, 0, 0, 0, 0, 1, "hold3_rel",    mk(S0, 0, 0, 0, 0, 0, 3, 0));

        step(1, 0, 0, 1, 0, 0, 1, "tmo_start",    mk(SM, 0, 1, 0, 0, 0, 3, 0));
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, 0, 0, 0, 1, "tmo_busy", mk(SM, 0, 0, 1, 0, 0, 3, 32'(k)));
        end
        step(1, 0, 0, 0, 0, 0, 1, "tmo_hit",      mk(S0, 0, 0, 1, 1, 0, 3, 4));
        step(1, 0, 0, 0, 0, 0, 1, "tmo_after",    mk(S0, 0, 0, 0, 0, 1, 3, 4));
        step(1, 0, 0, 0, 0, 0, 1, "tmo_sticky",   mk(S0, 0, 0, 0, 0, 1, 3, 4));

        step(1, 0, 0, 1, 0, 0, 1, "rst_mid_start", mk(SM, 0, 1, 0, 0, 1, 3, 4));
        step(1, 0, 0, 0, 0, 0, 1, "rst_mid_busy",  mk(SM, 0, 0, 1, 0, 1, 3, 5));
        step(1, 1, 0, 0, 0, 0, 0, "", mk(S0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0, 1, "rst_mid_after", mk(S0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending entries, required 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
